ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk  in  1  rising-edge clock.
REQ-002 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port valid_i  in  1  ID/EX slot holds a live instruction.
REQ-004 SHALL have ports pc_incr_i, rd_data1_i, rd_data2_i, imm_se_i, wr_addr_i  in  32 each  ID/EX register outputs.
REQ-005 SHALL have port alu_op_i  in  4  op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11-15 reserved.
REQ-006 SHALL have port alu_src_i  in  1  operand B select: 1 = imm_se_i, 0 = rd_data2_i.
REQ-007 SHALL have port flush_i  in  1  kill the current instruction and any multiply in progress.
REQ-008 SHALL have port stall_o  out  1  hold ID/EX and earlier stages.
REQ-009 SHALL have ports valid_o  out  1, alu_result_o  out  32, rd_data2_o  out  32, wr_addr_o  out  32, pc_incr_o  out  32  EX/MEM register.

Function
REQ-010 SHALL compute A = rd_data1_i and B = alu_src_i ? imm_se_i : rd_data2_i.
REQ-011 SHALL take the shift amount from B[4:0] only.
REQ-012 SHALL wrap ADD/SUB modulo 2^32 with no overflow flag.
REQ-013 SHALL give SLT/SLTU a result of 32'd1 or 32'd0, using a signed or unsigned compare respectively.
REQ-014 SHALL give reserved ops a result of 0, with valid passed through.
REQ-015 SHALL register the result of single-cycle ops (0-9, 11-15) into the EX/MEM outputs on the next rising edge, with latency 1 and stall_o = 0.
REQ-016 SHALL compute MUL as the low 32 bits of A*B, using an iterative shift-add of 1 bit per cycle.
REQ-017 SHALL implement the FSM states IDLE and BUSY, plus a 5-bit iteration counter cnt.
REQ-018 SHALL, in IDLE with valid_i=1 and op=MUL: drive stall_o=1; on the edge, capture A and B, clear the accumulator, set cnt=0, go to BUSY, and write a bubble (valid_o=0) to the EX/MEM register.
REQ-019 SHALL, in BUSY: drive stall_o = (cnt != 31); on each edge, add the multiplicand to the accumulator if the multiplier LSB is 1, shift the multiplicand left and the multiplier right, and increment cnt.
REQ-020 SHALL, in BUSY with cnt=31: on the edge, write the final product to alu_result_o, write the held rd_data2_i, wr_addr_i and pc_incr_i, set valid_o=1, and return to IDLE.
REQ-021 SHALL make a MUL hold the inputs for exactly 33 cycles, with valid_o rising after the 33rd edge.
REQ-022 SHALL write a bubble (valid_o=0) to the EX/MEM register on every stalled edge; all other EX/MEM data fields are don't-care when valid_o=0.
REQ-023 SHALL, with flush_i=1: force stall_o=0; on the edge, write valid_o=0, go to IDLE, and discard any partial product. Flush takes priority over all other behaviour.
REQ-024 SHALL, with valid_i=0 in IDLE: write valid_o=0 and keep stall_o=0 regardless of alu_op_i.
REQ-025 SHALL never have the iteration counter wrap while in BUSY; the exit at cnt=31 is mandatory.

Reset
REQ-026 SHALL, while rst_n=0: immediately clear valid_o, alu_result_o, rd_data2_o, wr_addr_o and pc_incr_o to 0, set state=IDLE, cnt=0, accumulator=0, and drive stall_o=0.
REQ-027 SHALL, when reset is asserted mid-multiply, abandon the multiply with no result emitted after release.
REQ-028 SHALL act on the first rising edge after rst_n deasserts as normal IDLE operation.

Verification
REQ-029 ADD: A=0xFFFFFFFF, rd_data2=1, alu_src=0 -> after 1 edge, valid_o=1, alu_result_o=0, stall_o=0 throughout.
REQ-030 SRA: A=0x80000000, imm=0x00000024, alu_src=1 -> shift by 4, alu_result_o=0xF8000000; SLT -1 vs 1 -> 1; SLTU -1 vs 1 -> 0.
REQ-031 MUL: A=0x00012345, B=0x00000100 held -> stall_o=1 for 32 cycles then 0 for 1 cycle; after the 33rd edge, valid_o=1 and alu_result_o=0x01234500; bubbles (valid_o=0) on the preceding 32 edges.
REQ-032 MUL overflow: A=0xFFFFFFFF, B=0xFFFFFFFF -> alu_result_o=0x00000001.
REQ-033 flush_i pulsed at BUSY cnt=10 -> stall_o=0 that cycle, valid_o=0 next, FSM in IDLE; a following ADD 2+3 gives result 5 one edge later.
REQ-034 rst_n dropped at BUSY cnt=5 -> all outputs 0 asynchronously; after release with valid_i=0, valid_o stays 0 and stall_o=0.

Source files
------------

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the execute stage.
// master = upstream pipeline driving ID/EX fields, slave = ex_stage.
interface ex_stage_if;
    logic        valid_i;
    logic [31:0] pc_incr_i;
    logic [31:0] rd_data1_i;
    logic [31:0] rd_data2_i;
    logic [31:0] imm_se_i;
    logic [31:0] wr_addr_i;
    logic [3:0]  alu_op_i;
    logic        alu_src_i;
    logic        flush_i;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] alu_result_o;
    logic [31:0] rd_data2_o;
    logic [31:0] wr_addr_o;
    logic [31:0] pc_incr_o;

    modport master (
        output valid_i, pc_incr_i, rd_data1_i, rd_data2_i, imm_se_i, wr_addr_i,
        output alu_op_i, alu_src_i, flush_i,
        input  stall_o, valid_o, alu_result_o, rd_data2_o, wr_addr_o, pc_incr_o
    );

    modport slave (
        input  valid_i, pc_incr_i, rd_data1_i, rd_data2_i, imm_se_i, wr_addr_i,
        input  alu_op_i, alu_src_i, flush_i,
        output stall_o, valid_o, alu_result_o, rd_data2_o, wr_addr_o, pc_incr_o
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus a 1-bit-per-cycle shift-add multiplier
// that stalls upstream until the product is written to the EX/MEM register.
module ex_stage (
    input  logic      clk,
    input  logic      rst_n,
    ex_stage_if.slave ex
);
    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAnd  = 4'd2;
    localparam logic [3:0] OpOr   = 4'd3;
    localparam logic [3:0] OpXor  = 4'd4;
    localparam logic [3:0] OpSll  = 4'd5;
    localparam logic [3:0] OpSrl  = 4'd6;
    localparam logic [3:0] OpSra  = 4'd7;
    localparam logic [3:0] OpSlt  = 4'd8;
    localparam logic [3:0] OpSltu = 4'd9;
    localparam logic [3:0] OpMul  = 4'd10;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic        valid_q, valid_d;
    logic [31:0] result_q, result_d;
    logic [31:0] rd2_q, rd2_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] pc_incr_q, pc_incr_d;
    logic        stall;

    logic [31:0] op_a, op_b, alu_res, acc_sum;
    logic [4:0]  shamt;

    assign op_a    = ex.rd_data1_i;
    assign op_b    = ex.alu_src_i ? ex.imm_se_i : ex.rd_data2_i;
    assign shamt   = op_b[4:0];
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

    always_comb begin
        alu_res = 32'd0;
        case (ex.alu_op_i)
            OpAdd:   alu_res = op_a + op_b;
            OpSub:   alu_res = op_a - op_b;
            OpAnd:   alu_res = op_a & op_b;
            OpOr:    alu_res = op_a | op_b;
            OpXor:   alu_res = op_a ^ op_b;
            OpSll:   alu_res = op_a << shamt;
            OpSrl:   alu_res = op_a >> shamt;
            OpSra:   alu_res = $unsigned($signed(op_a) >>> shamt);
            OpSlt:   alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            OpSltu:  alu_res = {31'd0, op_a < op_b};
            default: alu_res = 32'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        valid_d   = 1'b0;
        result_d  = result_q;
        rd2_d     = rd2_q;
        wr_addr_d = wr_addr_q;
        pc_incr_d = pc_incr_q;
        stall     = 1'b0;

        if (ex.flush_i) begin
            state_d = StIdle;
            cnt_d   = 5'd0;
            acc_d   = 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ex.valid_i && ex.alu_op_i == OpMul) begin
                        stall    = 1'b1;
                        mcand_d  = op_a;
                        mplier_d = op_b;
                        acc_d    = 32'd0;
                        cnt_d    = 5'd0;
                        state_d  = StBusy;
                    end else begin
                        valid_d   = ex.valid_i;
                        result_d  = alu_res;
                        rd2_d     = ex.rd_data2_i;
                        wr_addr_d = ex.wr_addr_i;
                        pc_incr_d = ex.pc_incr_i;
                    end
                end
                StBusy: begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (cnt_q == 5'd31) begin
                        // Upstream is released this cycle, so its fields are still the held ones.
                        cnt_d     = 5'd0;
                        state_d   = StIdle;
                        valid_d   = 1'b1;
                        result_d  = acc_sum;
                        rd2_d     = ex.rd_data2_i;
                        wr_addr_d = ex.wr_addr_i;
                        pc_incr_d = ex.pc_incr_i;
                    end else begin
                        stall = 1'b1;
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            mcand_q   <= 32'd0;
            mplier_q  <= 32'd0;
            acc_q     <= 32'd0;
            valid_q   <= 1'b0;
            result_q  <= 32'd0;
            rd2_q     <= 32'd0;
            wr_addr_q <= 32'd0;
            pc_incr_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            rd2_q     <= rd2_d;
            wr_addr_q <= wr_addr_d;
            pc_incr_q <= pc_incr_d;
        end
    end

    // Stall is gated by reset so it reads 0 immediately while rst_n is low.
    assign ex.stall_o      = stall & rst_n;
    assign ex.valid_o      = valid_q;
    assign ex.alu_result_o = result_q;
    assign ex.rd_data2_o   = rd2_q;
    assign ex.wr_addr_o    = wr_addr_q;
    assign ex.pc_incr_o    = pc_incr_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU ops, multiply timing,
// flush and asynchronous reset behaviour.
module tb_ex_stage;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    ex_stage_if bus ();

    ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ex    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int NumOps = 11;
    logic [3:0]  t_op  [NumOps] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                                    4'd11, 4'd15};
    logic        t_src [NumOps] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                                    1'b0, 1'b1};
    logic [31:0] t_a   [NumOps] = '{32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'd1,
                                    32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                    32'd5, 32'd9};
    logic [31:0] t_b   [NumOps] = '{32'd7, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0, 32'h21,
                                    32'd4, 32'h24, 32'd1, 32'd1, 32'd3, 32'd2};
    logic [31:0] t_exp [NumOps] = '{32'hFFFFFFFE, 32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00,
                                    32'd2, 32'h08000000, 32'hF8000000, 32'd1, 32'd0, 32'd0,
                                    32'd0};

    task automatic drive(input logic v, input logic [3:0] op, input logic src,
                         input logic [31:0] a, input logic [31:0] b);
        bus.valid_i    = v;
        bus.alu_op_i   = op;
        bus.alu_src_i  = src;
        bus.rd_data1_i = a;
        bus.rd_data2_i = src ? 32'hDEAD0000 : b;
        bus.imm_se_i   = src ? b : 32'h12345678;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
        bus.flush_i   = 1'b0;
        bus.wr_addr_i = 32'd0;
        bus.pc_incr_i = 32'd0;
        #12;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.stall_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl valid=%b stall=%b required 0 0", bus.valid_o, bus.stall_o);
        end
        checks++;
        if ({bus.alu_result_o, bus.rd_data2_o, bus.wr_addr_o, bus.pc_incr_o} !== 128'd0) begin
            failures++;
            $display("FAIL reset_data res=%h rd2=%h wa=%h pc=%h required 0", bus.alu_result_o,
                     bus.rd_data2_o, bus.wr_addr_o, bus.pc_incr_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        @(negedge clk);
        drive(1'b1, 4'd0, 1'b0, 32'hFFFFFFFF, 32'd1);
        bus.wr_addr_i = 32'd7;
        bus.pc_incr_i = 32'h104;
        #1;
        checks++;
        if (bus.stall_o !== 1'b0) begin
            failures++;
            $display("FAIL add_stall stall=%b required 0", bus.stall_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.valid_o !== 1'b1 || bus.alu_result_o !== 32'd0) begin
            failures++;
            $display("FAIL add_result valid=%b res=%h required 1 00000000", bus.valid_o,
                     bus.alu_result_o);
        end
        checks++;
        if (bus.wr_addr_o !== 32'd7 || bus.pc_incr_o !== 32'h104 || bus.rd_data2_o !== 32'd1)
        begin
            failures++;
            $display("FAIL add_fields wa=%h pc=%h rd2=%h required 7 104 1", bus.wr_addr_o,
                     bus.pc_incr_o, bus.rd_data2_o);
        end
    endtask

    task automatic test_ops();
        for (int i = 0; i < NumOps; i++) begin
            @(negedge clk);
            drive(1'b1, t_op[i], t_src[i], t_a[i], t_b[i]);
            @(posedge clk);
            #1;
            checks++;
            if (bus.valid_o !== 1'b1 || bus.alu_result_o !== t_exp[i] || bus.stall_o !== 1'b0)
            begin
                failures++;
                $display("FAIL op%0d valid=%b res=%h stall=%b required 1 %h 0", t_op[i],
                         bus.valid_o, bus.alu_result_o, bus.stall_o, t_exp[i]);
            end
            checks++;
            if (bus.rd_data2_o !== (t_src[i] ? 32'hDEAD0000 : t_b[i])) begin
                failures++;
                $display("FAIL op%0d_rd2 rd2=%h", t_op[i], bus.rd_data2_o);
            end
        end
    endtask

    task automatic test_idle_invalid();
        @(negedge clk);
        drive(1'b0, 4'd10, 1'b0, 32'd3, 32'd4);
        #1;
        checks++;
        if (bus.stall_o !== 1'b0) begin
            failures++;
            $display("FAIL invalid_stall stall=%b required 0", bus.stall_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL invalid_valid valid=%b required 0", bus.valid_o);
        end
    endtask

    task automatic test_mul(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] expv, input string name);
        @(negedge clk);
        drive(1'b1, 4'd10, 1'b0, a, b);
        bus.wr_addr_i = 32'd9;
        bus.pc_incr_i = 32'h200;
        for (int c = 1; c <= 33; c++) begin
            #1;
            checks++;
            if (bus.stall_o !== (c <= 32)) begin
                failures++;
                $display("FAIL %s_stall_c%0d stall=%b required %b", name, c, bus.stall_o,
                         c <= 32);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.valid_o !== (c == 33)) begin
                failures++;
                $display("FAIL %s_valid_c%0d valid=%b required %b", name, c, bus.valid_o,
                         c == 33);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.alu_result_o !== expv || bus.wr_addr_o !== 32'd9 || bus.pc_incr_o !== 32'h200
            || bus.rd_data2_o !== b) begin
            failures++;
            $display("FAIL %s_result res=%h wa=%h pc=%h rd2=%h required %h 9 200 %h", name,
                     bus.alu_result_o, bus.wr_addr_o, bus.pc_incr_o, bus.rd_data2_o, expv, b);
        end
        drive(1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_flush();
        @(negedge clk);
        drive(1'b1, 4'd10, 1'b0, 32'd77, 32'd3);
        // 1 capture edge + 10 BUSY edges leaves cnt = 10.
        repeat (11) @(negedge clk);
        bus.flush_i = 1'b1;
        #1;
        checks++;
        if (bus.stall_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall stall=%b required 0", bus.stall_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_valid valid=%b required 0", bus.valid_o);
        end
        @(negedge clk);
        bus.flush_i = 1'b0;
        drive(1'b1, 4'd0, 1'b0, 32'd2, 32'd3);
        #1;
        checks++;
        if (bus.stall_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle stall=%b required 0", bus.stall_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.valid_o !== 1'b1 || bus.alu_result_o !== 32'd5) begin
            failures++;
            $display("FAIL flush_add valid=%b res=%h required 1 00000005", bus.valid_o,
                     bus.alu_result_o);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(1'b1, 4'd0, 1'b0, 32'd10, 32'd20);
        @(posedge clk);
        #1;
        checks++;
        if (bus.valid_o !== 1'b1 || bus.alu_result_o !== 32'd30) begin
            failures++;
            $display("FAIL b2b_add valid=%b res=%h required 1 0000001e", bus.valid_o,
                     bus.alu_result_o);
        end
        @(negedge clk);
        drive(1'b1, 4'd1, 1'b0, 32'd10, 32'd20);
        @(posedge clk);
        #1;
        checks++;
        if (bus.valid_o !== 1'b1 || bus.alu_result_o !== 32'hFFFFFFF6) begin
            failures++;
            $display("FAIL b2b_sub valid=%b res=%h required 1 fffffff6", bus.valid_o,
                     bus.alu_result_o);
        end
    endtask

    task automatic test_reset_mid_mul();
        int bad;
        @(negedge clk);
        drive(1'b1, 4'd10, 1'b0, 32'd6, 32'd7);
        // 1 capture edge + 5 BUSY edges leaves cnt = 5.
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.stall_o !== 1'b0 || bus.alu_result_o !== 32'd0 ||
            bus.rd_data2_o !== 32'd0 || bus.wr_addr_o !== 32'd0 || bus.pc_incr_o !== 32'd0)
        begin
            failures++;
            $display("FAIL midreset_async valid=%b stall=%b res=%h rd2=%h wa=%h pc=%h required 0",
                     bus.valid_o, bus.stall_o, bus.alu_result_o, bus.rd_data2_o, bus.wr_addr_o,
                     bus.pc_incr_o);
        end
        drive(1'b0, 4'd10, 1'b0, 32'd6, 32'd7);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.valid_o !== 1'b0 || bus.stall_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL midreset_after bad_cycles=%0d required 0", bad);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add();
        test_ops();
        test_idle_invalid();
        test_mul(32'h00012345, 32'h00000100, 32'h01234500, "mul");
        test_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul_ovf");
        test_flush();
        test_back_to_back();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
